mem_bus_ctrl: RTL

Data-side bus controller directly downstream of the single-cycle MIPS datapath. It consumes the datapath's memory address, write data and the control unit's read/write strobes, then decodes them into three targets: data RAM, local I/O registers, and a handshaked slow peripheral port. It returns read data to the datapath and drives the datapath `enable`, which stalls the processor while a multi-cycle access completes.

---
 rtl/mem_bus_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// Data-side bus controller: decodes CPU loads/stores into data RAM, local I/O registers and a handshaked peripheral port.
// Stalls the datapath (cpu_enable=0) for one cycle on RAM reads and until ack/timeout on peripheral accesses.
module mem_bus_ctrl #(
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] DMEM_BASE  = 32'h10010000,
    parameter logic [31:0] IO_BASE    = 32'hFFFF0000,
    parameter int          TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   cpu_addr,
    input  logic [31:0]                   cpu_wdata,
    input  logic                          cpu_wr,
    input  logic                          cpu_rd,
    output logic [31:0]                   cpu_rdata,
    output logic                          cpu_enable,
    output logic [$clog2(DMEM_WORDS)-1:0] dmem_addr,
    output logic                          dmem_we,
    output logic [31:0]                   dmem_wdata,
    input  logic [31:0]                   dmem_rdata,
    output logic                          per_req,
    output logic                          per_we,
    output logic [3:0]                    per_addr,
    output logic [31:0]                   per_wdata,
    input  logic                          per_ack,
    input  logic [31:0]                   per_rdata,
    output logic [15:0]                   led_out,
    output logic                          bus_error
);

    localparam int          AW       = $clog2(DMEM_WORDS);
    localparam int          CW       = $clog2(TIMEOUT + 1);
    localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(4 * DMEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DMEM_RD,
        S_PER_WAIT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_q, wait_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [15:0]    led_q, led_d;
    logic           err_q, err_d;
    logic [31:0]    cyc_q;

    logic [31:0] io_off;
    logic        aligned, access, in_dmem, in_led, in_cyc, in_per;

    // Simultaneous rd+wr resolves to a write, so only cpu_wr selects direction.
    assign io_off  = cpu_addr - IO_BASE;
    assign aligned = (cpu_addr[1:0] == 2'b00);
    assign access  = cpu_rd | cpu_wr;
    assign in_dmem = aligned && (cpu_addr >= DMEM_BASE) && (cpu_addr < DMEM_END);
    assign in_led  = aligned && (io_off == 32'h0);
    assign in_cyc  = aligned && (io_off == 32'h4);
    assign in_per  = aligned && (io_off[31:6] == 26'd1);

    assign dmem_addr  = cpu_addr[AW+1:2];
    assign dmem_wdata = cpu_wdata;
    assign per_we     = cpu_wr;
    assign per_addr   = cpu_addr[5:2];
    assign per_wdata  = cpu_wdata;
    assign led_out    = led_q;
    assign bus_error  = err_q;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        led_d      = led_q;
        err_d      = err_q;
        cpu_rdata  = 32'h0;
        cpu_enable = 1'b1;
        dmem_we    = 1'b0;
        per_req    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (in_dmem) begin
                        if (cpu_wr) begin
                            dmem_we = 1'b1;
                        end else begin
                            cpu_enable = 1'b0;
                            state_d    = S_DMEM_RD;
                        end
                    end else if (in_led) begin
                        if (cpu_wr) led_d = cpu_wdata[15:0];
                        else        cpu_rdata = {16'h0, led_q};
                    end else if (in_cyc) begin
                        if (!cpu_wr) cpu_rdata = cyc_q;
                    end else if (in_per) begin
                        cpu_enable = 1'b0;
                        wait_d     = '0;
                        state_d    = S_PER_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DMEM_RD: begin
                cpu_rdata = dmem_rdata;
                state_d   = S_IDLE;
            end
            S_PER_WAIT: begin
                per_req    = 1'b1;
                cpu_enable = 1'b0;
                if (per_ack) begin
                    rdata_d = per_rdata;
                    state_d = S_DONE;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = 32'hDEADBEEF;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                cpu_rdata = cpu_wr ? 32'h0 : rdata_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Side-effecting strobes must never reach the bus while reset is held.
        if (reset) begin
            dmem_we = 1'b0;
            per_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            rdata_q <= 32'h0;
            led_q   <= 16'h0;
            err_q   <= 1'b0;
            cyc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            err_q   <= err_d;
            cyc_q   <= cyc_q + 32'd1;
        end
    end

endmodule
